// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Fixed-point format, constants, arctangent table and state
//                encoding shared by the CORDIC vectoring and rotation engines.
//                Magnitude compensation is selected by the macro
//                CORDIC_MAG_COMPENSATION_EN in the engine that uses K.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

  // Q3.29 external format: sign bit plus 2 integer bits
  localparam int DATA_WIDTH    = 32;
  localparam int POINT_POS     = 3;
  localparam int REG_EXTENSION = 4;
  // Must not exceed the 32 entries of ATAN_TABLE
  localparam int ITERATIONS    = 28;
  localparam int CNT_WIDTH     = 5;
  // Internal width: 2 guard MSBs above the external format, REG_EXTENSION below
  localparam int INT_WIDTH     = DATA_WIDTH + REG_EXTENSION + 2;

  localparam logic signed [DATA_WIDTH-1:0] PI   = 32'h6487ED51;
  localparam logic signed [DATA_WIDTH-1:0] PI_2 = 32'h3243F6A9;

  // K = 0.6072529350 in Q1.31
  localparam logic signed [DATA_WIDTH-1:0] K      = 32'h4DBA76D4;
  localparam int                           K_FRAC = 31;

  // atan(2^-i) in Q3.29, rounded to nearest
  localparam logic [DATA_WIDTH-1:0] ATAN_TABLE [32] = '{
    32'h1921FB54, 32'h0ED63383, 32'h07D6DD7E, 32'h03FAB753,
    32'h01FF55BB, 32'h00FFEAAE, 32'h007FFD55, 32'h003FFFAB,
    32'h001FFFF5, 32'h000FFFFF, 32'h00080000, 32'h00040000,
    32'h00020000, 32'h00010000, 32'h00008000, 32'h00004000,
    32'h00002000, 32'h00001000, 32'h00000800, 32'h00000400,
    32'h00000200, 32'h00000100, 32'h00000080, 32'h00000040,
    32'h00000020, 32'h00000010, 32'h00000008, 32'h00000004,
    32'h00000002, 32'h00000001, 32'h00000000, 32'h00000000
  };

  typedef logic signed [INT_WIDTH-1:0] ireg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_SCALE = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Sign-extend into the guard bits and append the extension LSBs
  function automatic ireg_t widen(input logic [DATA_WIDTH-1:0] v);
    return {{2{v[DATA_WIDTH-1]}}, v, {REG_EXTENSION{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_vectoring_if.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_vectoring_if
//  Description : Request/result bundle of the CORDIC vectoring engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cordic_vectoring_if;
  import cordic_pkg::*;

  logic                  start;
  logic [DATA_WIDTH-1:0] x_in;
  logic [DATA_WIDTH-1:0] y_in;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] mag;
  logic [DATA_WIDTH-1:0] angle;

  modport master (output start, x_in, y_in, input  busy, done, mag, angle);
  modport slave  (input  start, x_in, y_in, output busy, done, mag, angle);
endinterface
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_atan_rom
//  Description : Combinational atan(2^-i) lookup indexed by the iteration
//                counter; shared with the rotation engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [CNT_WIDTH-1:0]  idx_i,
  output logic [DATA_WIDTH-1:0] atan_o
);

  assign atan_o = ATAN_TABLE[idx_i];

endmodule
`default_nettype wire

// File: rtl/cordic_vectoring.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_vectoring
//  Description : Iterative CORDIC in vectoring mode. Converts (X, Y) to
//                magnitude and four-quadrant angle atan2(Y, X) in Q3.29.
//                Define CORDIC_MAG_COMPENSATION_EN to add the SCALE state that
//                multiplies the magnitude by K; otherwise MAG carries the raw
//                CORDIC gain and latency is one cycle shorter.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_vectoring
  import cordic_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  cordic_vectoring_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAG_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(ITERATIONS - 1);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  ireg_t                 x_q, x_d, y_q, y_d, z_q, z_d;
  logic                  zero_q, zero_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] mag_q, mag_d, angle_q, angle_d;

  logic [DATA_WIDTH-1:0] x_clamp, y_clamp, atan_w, mag_res;
  ireg_t                 atan_ext, x_shift, y_shift;
  logic                  mag_ovf;

  cordic_atan_rom u_atan_rom (
    .idx_i  (cnt_q),
    .atan_o (atan_w)
  );

  // The most negative code has no positive counterpart; pull it in by one LSB
  assign x_clamp  = (bus.x_in == MOST_NEG) ? MOST_NEG + DATA_WIDTH'(1) : bus.x_in;
  assign y_clamp  = (bus.y_in == MOST_NEG) ? MOST_NEG + DATA_WIDTH'(1) : bus.y_in;

  assign atan_ext = widen(atan_w);
  assign x_shift  = x_q >>> cnt_q;
  assign y_shift  = y_q >>> cnt_q;

  // x is never negative after load, so any set bit above the external
  // sign position means the magnitude does not fit
  assign mag_ovf  = (x_q[INT_WIDTH-1 -: 3] != 3'b000);
  assign mag_res  = mag_ovf ? MAG_MAX : x_q[REG_EXTENSION +: DATA_WIDTH];

`ifdef CORDIC_MAG_COMPENSATION_EN
  logic signed [INT_WIDTH+DATA_WIDTH-1:0] prod;
  ireg_t                                  x_scaled;
  assign prod     = x_q * K;
  assign x_scaled = ireg_t'(prod >>> K_FRAC);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus datapath updates for each state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    mag_d   = mag_q;
    angle_d = angle_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // Pre-rotate left-half-plane vectors by -/+90 deg so the
          // micro-rotations only need to cover (-pi/2, +pi/2)
          if (!x_clamp[DATA_WIDTH-1]) begin
            x_d = widen(x_clamp);
            y_d = widen(y_clamp);
            z_d = '0;
          end else if (!y_clamp[DATA_WIDTH-1]) begin
            x_d = widen(y_clamp);
            y_d = -widen(x_clamp);
            z_d = widen(PI_2);
          end else begin
            x_d = -widen(y_clamp);
            y_d = widen(x_clamp);
            z_d = -widen(PI_2);
          end
          zero_d  = (bus.x_in == '0) && (bus.y_in == '0);
          cnt_d   = '0;
          state_d = ST_ITER;
        end
      end

      ST_ITER: begin
        // Rotate towards y = 0, accumulating the applied angle in z
        if (!y_q[INT_WIDTH-1]) begin
          x_d = x_q + y_shift;
          y_d = y_q - x_shift;
          z_d = z_q + atan_ext;
        end else begin
          x_d = x_q - y_shift;
          y_d = y_q + x_shift;
          z_d = z_q - atan_ext;
        end
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
`ifdef CORDIC_MAG_COMPENSATION_EN
          state_d = ST_SCALE;
`else
          state_d = ST_OUT;
`endif
        end
      end

`ifdef CORDIC_MAG_COMPENSATION_EN
      ST_SCALE: begin
        x_d     = x_scaled;
        state_d = ST_OUT;
      end
`endif

      ST_OUT: begin
        done_d  = 1'b1;
        mag_d   = zero_q ? '0 : mag_res;
        angle_d = zero_q ? '0 : z_q[REG_EXTENSION +: DATA_WIDTH];
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      mag_q   <= '0;
      angle_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      mag_q   <= mag_d;
      angle_q <= angle_d;
    end
  end

  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = done_q;
  assign bus.mag   = mag_q;
  assign bus.angle = angle_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_vectoring
//  Description : Self-checking bench for cordic_vectoring against a real-
//                arithmetic atan2/hypot reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_vectoring;
  import cordic_pkg::*;

`ifdef CORDIC_MAG_COMPENSATION_EN
  localparam int LAT = ITERATIONS + 2;
`else
  localparam int LAT = ITERATIONS + 1;
`endif
  localparam real Q29    = 536870912.0;
  localparam real PI_LSB = 3.141592653589793 * 536870912.0;
  localparam real TOL    = 32.0;

  logic clk = 1'b0;
  logic rst;
  cordic_vectoring_if bus ();

  cordic_vectoring dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  real gain;

  // Expected magnitude and angle (both in Q3.29 LSBs) from plain arithmetic
  function automatic void ref_model(input logic [31:0] x, input logic [31:0] y,
                                    output real em, output real ea);
    longint xs, ys;
    real    xr, yr;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    if (xs == -64'sd2147483648) xs = xs + 1;
    if (ys == -64'sd2147483648) ys = ys + 1;
    if (xs == 0 && ys == 0) begin
      em = 0.0;
      ea = 0.0;
      return;
    end
    xr = real'(xs);
    yr = real'(ys);
    ea = $atan2(yr, xr) * Q29;
    em = $sqrt(xr * xr + yr * yr) * gain;
    if (em > 2147483647.0) em = 2147483647.0;
  endfunction

  // Angular distance with wrap at +/-pi
  function automatic real ang_err(input logic [31:0] got, input real exp_a);
    real d;
    d = real'($signed(got)) - exp_a;
    if (d > PI_LSB)       d = d - 2.0 * PI_LSB;
    else if (d < -PI_LSB) d = d + 2.0 * PI_LSB;
    return (d < 0.0) ? -d : d;
  endfunction

  function automatic real mag_err(input logic [31:0] got, input real exp_m);
    real d;
    d = real'($signed(got)) - exp_m;
    return (d < 0.0) ? -d : d;
  endfunction

  // Issue one request and wait (bounded) for DONE
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic busy_start, output logic busy_done,
                        output logic [31:0] m, output logic [31:0] a);
    @(negedge clk);
    bus.x_in  = x;
    bus.y_in  = y;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    busy_start = bus.busy;
    lat        = 0;
    busy_done  = 1'b1;
    m          = '0;
    a          = '0;
    while (lat < LAT + 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) begin
        busy_done = bus.busy;
        m         = bus.mag;
        a         = bus.angle;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.x_in  = 32'h20000000;
    bus.y_in  = 32'h20000000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.mag !== 32'h0)   begin errors++; $display("FAIL reset_mag got=%h exp=0", bus.mag); end
    checks++; if (bus.angle !== 32'h0) begin errors++; $display("FAIL reset_angle got=%h exp=0", bus.angle); end
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_priority_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_directed();
    logic [31:0] xv [4];
    logic [31:0] yv [4];
    logic [31:0] av [4];
    int          lat;
    logic        bs, bd;
    logic [31:0] m, a;
    real         em, ea;
    xv = '{32'h20000000, 32'hE0000000, 32'h00000000, 32'h20000000};
    yv = '{32'h20000000, 32'h00000000, 32'hE0000000, 32'h00000000};
    av = '{32'h1921FB54, 32'h6487ED51, 32'hCDBC0957, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      run_op(xv[i], yv[i], lat, bs, bd, m, a);
      ref_model(xv[i], yv[i], em, ea);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      checks++; if (bs !== 1'b1) begin errors++; $display("FAIL dir%0d_busy_rise got=%b exp=1", i, bs); end
      checks++; if (bd !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_at_done got=%b exp=0", i, bd); end
      checks++; if (ang_err(a, real'($signed(av[i]))) > TOL)
        begin errors++; $display("FAIL dir%0d_angle got=%h exp=%h", i, a, av[i]); end
      checks++; if (mag_err(m, em) > TOL)
        begin errors++; $display("FAIL dir%0d_mag got=%h exp=%0.1f", i, m, em); end
`ifndef CORDIC_MAG_COMPENSATION_EN
      if (i == 3) begin
        checks++; if (mag_err(m, real'(32'h34B24291)) > TOL)
          begin errors++; $display("FAIL dir%0d_raw_gain_mag got=%h exp=34b24291", i, m); end
      end
`endif
      @(posedge clk);
      #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, bus.done); end
    end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic        bs, bd;
    logic [31:0] m, a;
    real         em, ea;
    @(negedge clk);
    bus.x_in  = 32'h20000000;
    bus.y_in  = 32'h20000000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0)   begin errors++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    checks++; if (bus.mag !== 32'h0)   begin errors++; $display("FAIL midrst_mag got=%h exp=0", bus.mag); end
    checks++; if (bus.angle !== 32'h0) begin errors++; $display("FAIL midrst_angle got=%h exp=0", bus.angle); end
    rst = 1'b0;
    run_op(32'h20000000, 32'h00000000, lat, bs, bd, m, a);
    ref_model(32'h20000000, 32'h00000000, em, ea);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL midrst_restart_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (ang_err(a, ea) > TOL) begin errors++; $display("FAIL midrst_angle_after got=%h exp=%0.1f", a, ea); end
    checks++; if (mag_err(m, em) > TOL) begin errors++; $display("FAIL midrst_mag_after got=%h exp=%0.1f", m, em); end
  endtask

  task automatic test_zero_ignore();
    int          ndone, first;
    logic [31:0] m, a;
    ndone = 0;
    first = -1;
    m     = 32'hFFFFFFFF;
    a     = 32'hFFFFFFFF;
    @(negedge clk);
    bus.x_in  = 32'h0;
    bus.y_in  = 32'h0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= LAT + 35; c++) begin
      if (c == 5) begin
        bus.x_in  = 32'h10000000;
        bus.y_in  = 32'h18000000;
        bus.start = 1'b1;
      end
      if (c == 6) bus.start = 1'b0;
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        if (first < 0) begin
          first = c;
          m     = bus.mag;
          a     = bus.angle;
        end
      end
    end
    checks++; if (ndone !== 1)   begin errors++; $display("FAIL zero_done_count got=%0d exp=1", ndone); end
    checks++; if (first !== LAT) begin errors++; $display("FAIL zero_latency got=%0d exp=%0d", first, LAT); end
    checks++; if (m !== 32'h0)   begin errors++; $display("FAIL zero_mag got=%h exp=0", m); end
    checks++; if (a !== 32'h0)   begin errors++; $display("FAIL zero_angle got=%h exp=0", a); end
  endtask

  task automatic test_back_to_back();
    int          lat1, lat2;
    logic        bs, bd;
    logic [31:0] m, a;
    real         em, ea;
    run_op(32'h10000000, 32'hF0000000, lat1, bs, bd, m, a);
    run_op(32'hF0000000, 32'h08000000, lat2, bs, bd, m, a);
    ref_model(32'hF0000000, 32'h08000000, em, ea);
    checks++; if (lat1 !== LAT) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat1, LAT); end
    checks++; if (lat2 !== LAT) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat2, LAT); end
    checks++; if (ang_err(a, ea) > TOL) begin errors++; $display("FAIL b2b_angle got=%h exp=%0.1f", a, ea); end
    checks++; if (mag_err(m, em) > TOL) begin errors++; $display("FAIL b2b_mag got=%h exp=%0.1f", m, em); end
  endtask

  task automatic test_clamp_saturate();
    logic [31:0] xv [3];
    logic [31:0] yv [3];
    int          lat;
    logic        bs, bd;
    logic [31:0] m, a;
    real         em, ea;
    xv = '{32'h80000000, 32'h00000000, 32'h80000000};
    yv = '{32'h00000000, 32'h80000000, 32'h80000000};
    for (int i = 0; i < 3; i++) begin
      run_op(xv[i], yv[i], lat, bs, bd, m, a);
      ref_model(xv[i], yv[i], em, ea);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL clamp%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      checks++; if (ang_err(a, ea) > TOL) begin errors++; $display("FAIL clamp%0d_angle got=%h exp=%0.1f", i, a, ea); end
      checks++; if (mag_err(m, em) > TOL) begin errors++; $display("FAIL clamp%0d_mag got=%h exp=%0.1f", i, m, em); end
    end
  endtask

  task automatic test_random();
    int          xi, yi, lat;
    logic        bs, bd;
    logic [31:0] m, a;
    real         em, ea;
    for (int n = 0; n < 24; n++) begin
      do begin
        xi = int'($urandom_range(32'h7FFFFFFF, 0)) - 1073741824;
        yi = int'($urandom_range(32'h7FFFFFFF, 0)) - 1073741824;
      end while ((xi < 0 ? -xi : xi) < 67108864 && (yi < 0 ? -yi : yi) < 67108864);
      run_op(xi, yi, lat, bs, bd, m, a);
      ref_model(xi, yi, em, ea);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", n, lat, LAT); end
      checks++; if (ang_err(a, ea) > TOL)
        begin errors++; $display("FAIL rnd%0d_angle x=%h y=%h got=%h exp=%0.1f", n, xi, yi, a, ea); end
      checks++; if (mag_err(m, em) > TOL)
        begin errors++; $display("FAIL rnd%0d_mag x=%h y=%h got=%h exp=%0.1f", n, xi, yi, m, em); end
    end
  endtask

  initial begin
    real p;
`ifdef CORDIC_MAG_COMPENSATION_EN
    gain = 1.0;
`else
    gain = 1.0;
    p    = 1.0;
    for (int i = 0; i < ITERATIONS; i++) begin
      gain = gain * $sqrt(1.0 + p);
      p    = p / 4.0;
    end
`endif
    test_reset();
    test_directed();
    test_reset_mid();
    test_zero_ignore();
    test_back_to_back();
    test_clamp_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
`default_nettype wire
